// File: rtl/five_one_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | five_one_arbiter: round-robin 5-way arbiter and select sequencer for the    |
// | shared 5:1 mux. Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD forced release|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module five_one_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [3:0] pos;
  logic       forced;

  // Rotating search starting at ptr; first set request in the rotation wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    pos        = 4'd0;
    for (int k = 0; k < 5; k++) begin
      pos = {1'b0, ptr_q} + 4'(k);
      if (pos > 4'd4) pos = pos - 4'd5;
      if (!pick_found && req[pos[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pos[2:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign forced = req[owner_q] && (hold_q == 8'(MAX_HOLD - 1));
`else
  logic [7:0] unused_max_hold;

  assign unused_max_hold = 8'(MAX_HOLD);
  assign forced          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, TURN: begin
        grant_d = 5'b00000;
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == 3'd4) ? 3'd0 : pick_idx + 3'd1;
          grant_d = 5'b00001 << pick_idx;
          sel_d   = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // No preemption: only the owner's own request (or the hold limit) ends it.
        if (!req[owner_q] || forced) begin
          state_d = TURN;
          grant_d = 5'b00000;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 5'b00000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q != GRANT && state_d == GRANT) begin
      hold_d = 8'd0;
    end else if (state_q == GRANT) begin
      hold_d    = hold_q + 8'd1;
      timeout_d = forced;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      grant_q <= 5'b00000;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/five_one_arbiter.md
# five_one_arbiter

Round-robin arbiter and select sequencer for the team's 5:1 single-bit mux. Five requesters compete for the shared mux output. The block grants one requester at a time and drives the mux `sel` code to match. It holds the grant until the owner releases, then inserts one turnaround cycle before the next grant, so the mux select never switches while a grant is active.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive GRANT cycles per owner. Legal range 2..255. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  5  request vector; bit i is requester i. Level-sensitive and held high for as long as the requester wants the resource.
- `grant`  out  5  registered one-hot grant, or all-zero.
- `sel`  out  3  registered mux select (0..4) driving the 5:1 mux.
- `busy`  out  1  registered; high whenever the state is not IDLE.
- `timeout`  out  1  registered one-cycle pulse on a forced release.

## Operation
State machine with three states: IDLE, GRANT, TURN.

Arbitration (performed in IDLE and in TURN):
- Search order is `ptr`, `ptr+1`, ..., modulo 5. The first set `req` bit wins.
- `ptr` is 3 bits, range 0..4. On each new grant to index i, `ptr` becomes i+1, wrapping 4 -> 0.

State transitions:
- IDLE -> GRANT when any `req` bit is set; otherwise stay in IDLE.
- GRANT: `grant` = one-hot of the owner and `sel` = owner index.
  - Stay in GRANT while `req[owner]` is high.
  - Go to TURN when `req[owner]` is sampled low.
  - Requests from other requesters are ignored during GRANT; there is no preemption.
- TURN lasts exactly one cycle with `grant` = 0. At the end of TURN:
  - go to GRANT (new owner by the search above) if any `req` bit is set;
  - otherwise go to IDLE.

Output rules:
- `sel` holds its last value in IDLE and TURN. It changes only on entry to GRANT.
- `sel` never takes the values 5, 6 or 7.
- `grant` is never multi-hot.

Reset:
- Reset values: `grant` = 0, `sel` = 0, `busy` = 0, `timeout` = 0, `ptr` = 0, state = IDLE, hold counter = 0.
- Asserting `rst_n` low mid-grant clears all of the above immediately (asynchronously). It does not wait for a clock edge.
- After `rst_n` deasserts, the first arbitration starts the search at requester 0.

## Timing
- Request to grant: `req` asserted before edge N in IDLE -> `grant`, `sel` and `busy` are valid after edge N (1-cycle latency).
- Release: `req[owner]` low before edge M -> `grant` = 0 after edge M (TURN). The next grant, if any request is pending, appears after edge M+1.
- The minimum gap between two grants is exactly one all-zero cycle.
- With all five requests continuously high and owners each releasing after one GRANT cycle, grants rotate 0,1,2,3,4,0,... Each grant is followed by one TURN cycle.

## Configuration
Macro: `ARB_TIMEOUT_EN`.

Defined:
- An 8-bit hold counter clears on entry to GRANT and increments on each GRANT cycle.
- When the owner has been in GRANT for `MAX_HOLD` cycles and `req[owner]` is still high, the block performs a forced release:
  - it goes to TURN;
  - `timeout` pulses high for that TURN cycle;
  - `ptr` is already past the owner, so the owner is served again only after the other pending requesters.
- If `req[owner]` drops on the same edge the limit is reached, this is a normal release and `timeout` stays 0.

Not defined:
- No hold counter is built and `timeout` is tied to 0.
- A grant is held indefinitely while `req[owner]` stays high.

## Test plan
- Reset with `req` = 5'b11111 held: `grant` = 0, `sel` = 0, `busy` = 0 during reset. After release, first `grant` = 5'b00001, `sel` = 0, one cycle later.
- All five requests high, each owner releasing after one GRANT cycle -> `sel` sequence 0,1,2,3,4,0 with one zero-`grant` cycle between grants. `ptr` wraps 4 -> 0.
- Owner 2 granted while `req[4]` rises -> `grant` stays 5'b00100 until `req[2]` drops. After one TURN cycle, `grant` = 5'b10000 and `sel` = 4.
- `rst_n` pulsed low mid-GRANT (owner 3) -> outputs clear without a clock edge. The next arbitration starts from requester 0.
- With `ARB_TIMEOUT_EN` and `MAX_HOLD` = 4, `req` = 5'b00011 held -> owner 0 held 4 cycles, then `timeout` = 1 for one cycle, then `grant` = 5'b00010. Without the macro, owner 0 is held indefinitely and `timeout` stays 0.
- With `ARB_TIMEOUT_EN`, the owner drops `req` on its 4th GRANT cycle -> normal release and `timeout` stays 0.
